// File: rtl/unified_mem.sv
// rtl/unified_mem.sv - shared single-port byte-writable memory for fetch and load/store
// Data has priority; fetch wins after STARVE_MAX consecutive stalls.
module unified_mem #(
    parameter int    DATA_W     = 32,
    parameter int    ADDR_W     = 10,
    parameter int    RD_LAT     = 2,
    parameter int    STARVE_MAX = 3,
    parameter string INIT_FILE  = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_ce,
    input  logic [31:0]         inst_addr,
    output logic                inst_stall,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_valid,
    input  logic                data_ce,
    input  logic                data_we,
    input  logic [31:0]         data_addr,
    input  logic [DATA_W/8-1:0] data_sel,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_stall,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_valid
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam int LAST  = RD_LAT - 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SW-1:0]     starve_q, starve_d;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] tag_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] inst_hold_q, data_hold_q;

    logic              inst_grant, data_grant, rd_en;
    logic [ADDR_W-1:0] inst_idx, data_idx, rd_idx;
    logic              unused_addr;

    assign inst_idx    = inst_addr[ADDR_W+OFF-1:OFF];
    assign data_idx    = data_addr[ADDR_W+OFF-1:OFF];
    assign unused_addr = ^{inst_addr, data_addr};

    assign inst_stall = inst_ce & data_ce & (starve_q != SW'(STARVE_MAX));
    assign data_stall = inst_ce & data_ce & (starve_q == SW'(STARVE_MAX));
    assign inst_grant = inst_ce & ~inst_stall;
    assign data_grant = data_ce & ~data_stall;
    assign rd_en      = inst_grant | (data_grant & ~data_we);
    assign rd_idx     = data_grant ? data_idx : inst_idx;

    // inst_stall only asserts below STARVE_MAX, so the increment saturates by construction.
    always_comb begin
        starve_d = '0;
        if (inst_stall) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (data_grant && data_we) begin
            for (int b = 0; b < NB; b++) begin
                if (data_sel[b]) mem[data_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
            end
        end
        if (rd_en) dat_q[0] <= mem[rd_idx];
        for (int s = 1; s < RD_LAT; s++) dat_q[s] <= dat_q[s-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q    <= '0;
            vld_q       <= '0;
            tag_q       <= '0;
            inst_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            starve_q    <= starve_d;
            vld_q[0]    <= rd_en;
            tag_q[0]    <= data_grant;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
            inst_hold_q <= inst_rdata;
            data_hold_q <= data_rdata;
        end
    end

    // Tag 1 marks a load/store-port read; rdata falls back to the last delivered word.
    assign inst_valid = vld_q[LAST] & ~tag_q[LAST];
    assign data_valid = vld_q[LAST] &  tag_q[LAST];
    assign inst_rdata = inst_valid ? dat_q[LAST] : inst_hold_q;
    assign data_rdata = data_valid ? dat_q[LAST] : data_hold_q;

endmodule

// File: tb/tb_unified_mem.sv
// tb/tb_unified_mem.sv - directed self-checking bench for unified_mem
module tb_unified_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic        inst_stall;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        data_ce;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_sel;
    logic [31:0] data_wdata;
    logic        data_stall;
    logic [31:0] data_rdata;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem #(
        .DATA_W(32), .ADDR_W(10), .RD_LAT(2), .STARVE_MAX(3), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst),
        .inst_ce(inst_ce), .inst_addr(inst_addr), .inst_stall(inst_stall),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .data_ce(data_ce), .data_we(data_we), .data_addr(data_addr),
        .data_sel(data_sel), .data_wdata(data_wdata), .data_stall(data_stall),
        .data_rdata(data_rdata), .data_valid(data_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        inst_ce = 1'b0;
        data_ce = 1'b0;
        data_we = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        data_ce = 1'b1; data_we = 1'b1; data_addr = a; data_wdata = d; data_sel = s;
    endtask

    task automatic load(input logic [31:0] a);
        @(negedge clk);
        data_ce = 1'b1; data_we = 1'b0; data_addr = a;
    endtask

    // Load issued at negedge n is accepted at the next posedge; with RD_LAT=2 valid shows at negedge n+2.
    task automatic load_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
        load(a);
        @(negedge clk);
        idle();
        #1 chk({tag, "_early"}, {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        #1 chk({tag, "_valid"}, {31'd0, data_valid}, 32'd1);
        chk({tag, "_data"}, data_rdata, exp);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b0;
        inst_addr = '0; data_addr = '0; data_sel = '0; data_wdata = '0;
        idle();

        @(negedge clk);
        #1 chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        inst_ce = 1'b1; data_ce = 1'b1;
        #1 chk("rst_inst_stall", {31'd0, inst_stall}, 32'd1);
        chk("rst_data_stall", {31'd0, data_stall}, 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b1;

        // Byte-lane store merge.
        store(32'h10, 32'hAABBCCDD, 4'b1111);
        #1 chk("st_data_stall", {31'd0, data_stall}, 32'd0);
        store(32'h10, 32'h11223344, 4'b0101);
        load_check(32'h10, 32'hAA22CC44, "lanes");
        @(negedge clk);
        #1 chk("lanes_hold_valid", {31'd0, data_valid}, 32'd0);
        chk("lanes_hold_data", data_rdata, 32'hAA22CC44);

        // Preload words 0..3, then fetch them back to back.
        for (int i = 0; i < 4; i++) store(32'(4 * i), 32'(i + 1), 4'b1111);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            idle();
            inst_ce   = (i < 4);
            inst_addr = 32'(4 * i);
            #1;
            if (i < 4) chk("fetch_stall", {31'd0, inst_stall}, 32'd0);
            chk("fetch_valid", {31'd0, inst_valid}, {31'd0, (i >= 2 && i <= 5)});
            if (i >= 2 && i <= 5) chk("fetch_data", inst_rdata, 32'(i - 1));
        end
        chk("fetch_hold", inst_rdata, 32'd4);

        // Contention: grant order D D D I D D D I (bit set = inst granted).
        pat = 8'b1000_1000;
        inst_addr = 32'h0;
        data_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inst_ce = (i < 8);
            data_ce = (i < 8);
            data_we = 1'b0;
            #1;
            if (i < 8) begin
                chk("arb_data_stall", {31'd0, data_stall}, {31'd0, pat[i]});
                chk("arb_inst_stall", {31'd0, inst_stall}, {31'd0, ~pat[i]});
            end
            if (i >= 2) begin
                chk("arb_inst_valid", {31'd0, inst_valid}, {31'd0, pat[i-2]});
                chk("arb_data_valid", {31'd0, data_valid}, {31'd0, ~pat[i-2]});
            end
        end
        idle();

        // Address wrap, read-after-write, and an empty-lane store.
        store(32'h1000, 32'h5A5A5A5A, 4'b1111);
        load_check(32'h0, 32'h5A5A5A5A, "wrap");
        store(32'h20, 32'h12345678, 4'b1111);
        load_check(32'h20, 32'h12345678, "raw");
        store(32'h20, 32'hFFFFFFFF, 4'b0000);
        load_check(32'h23, 32'h12345678, "sel0");

        // Asynchronous reset with reads in flight.
        load(32'h20);
        load(32'h10);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        #1 chk("mid_rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_data_rdata", data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("post_rst_data_valid", {31'd0, data_valid}, 32'd0);
            chk("post_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        chk("post_rst_data_rdata", data_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
